instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: loads host instructions into instruction memory, one write per two cycles.
// Define ENC_CHECK_EN to compile in the operand legality check and the ERR path.
`ifndef IMEMADDRW
`define IMEMADDRW 10
`endif
`ifndef OPR_W
`define OPR_W 6
`endif
`ifndef SRC_W
`define SRC_W 9
`endif

module instr_encoder (
   input  logic                         clk,
   input  logic                         rst_b,
   input  logic                         start,
   input  logic [`IMEMADDRW-1:0]        base_addr,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [`OPR_W-1:0]            req_opr,
   input  logic [2:0]                   req_mode,
   input  logic [`SRC_W-4:0]            req_field,
   input  logic                         req_last,
   output logic                         imem_we_b,
   output logic [`IMEMADDRW-1:0]        imem_addr,
   output logic [`OPR_W+`SRC_W-1:0]     imem_wdata,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [`IMEMADDRW-1:0]        err_addr,
   output logic [`IMEMADDRW:0]          instr_cnt
);
   localparam int unsigned AW = `IMEMADDRW;
   localparam int unsigned OW = `OPR_W;
   localparam int unsigned FW = `SRC_W - 3;
   localparam int unsigned WW = `OPR_W + `SRC_W;

   typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [WW-1:0]   word_q, word_d;
   logic            last_q, last_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            legal;

`ifdef ENC_CHECK_EN
   logic            err_q, err_d;
   logic [AW-1:0]   eaddr_q, eaddr_d;
   logic            fld_idx;
   logic            opr_noidx;

   // Fields 32/33 name the index registers; some opcodes may not use them directly.
   always_comb begin
      fld_idx   = (req_field == FW'(32)) || (req_field == FW'(33));
      opr_noidx = (req_opr == OW'(5)) || (req_opr == OW'(9)) || (req_opr == OW'(11));
      case (req_mode)
         3'b000:  legal = (req_field < FW'(8)) || (fld_idx && !opr_noidx);
         3'b010:  legal = 1'b1;
         3'b100:  legal = (req_field == '0);
         3'b101:  legal = fld_idx;
         default: legal = 1'b0;
      endcase
   end

   assign err      = err_q;
   assign err_addr = eaddr_q;
`else
   assign legal    = 1'b1;
   assign err      = 1'b0;
   assign err_addr = '0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      word_d  = word_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
`ifdef ENC_CHECK_EN
      err_d   = err_q;
      eaddr_d = eaddr_q;
`endif
      case (state_q)
         IDLE, ERR: begin
            if (start) begin
               state_d = RUN;
               ptr_d   = base_addr;
               cnt_d   = '0;
`ifdef ENC_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            if (req_valid) begin
               word_d = {req_opr, req_mode, req_field};
               last_d = req_last;
               if (legal) begin
                  state_d = WRITE;
               end else begin
                  state_d = ERR;
`ifdef ENC_CHECK_EN
                  err_d   = 1'b1;
                  eaddr_d = ptr_q;
`endif
               end
            end
         end
         WRITE: begin
            ptr_d   = ptr_q + 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            state_d = last_q ? DONE : RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef ENC_CHECK_EN
         err_q   <= 1'b0;
         eaddr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         word_q  <= word_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
`ifdef ENC_CHECK_EN
         err_q   <= err_d;
         eaddr_q <= eaddr_d;
`endif
      end
   end

   // Strobes decode straight from state so reset drops the write enable asynchronously.
   assign imem_we_b  = (state_q != WRITE);
   assign imem_addr  = ptr_q;
   assign imem_wdata = word_q;
   assign req_ready  = (state_q == RUN);
   assign busy       = (state_q != IDLE) && (state_q != ERR);
   assign done       = (state_q == DONE);
   assign instr_cnt  = cnt_q;

endmodule
